write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer.sv | 197 +++++++++++++++++++
 tb/tb_write_buffer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// Posted write buffer between cache controller and RAM; coalesces writes and serves reads from buffered data.
// Writes and buffer-hit reads complete 1 cycle after accept; misses wait on RAM; cacheReady drops when busy or full.
module write_buffer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cacheRead,
  input  logic                    cacheWrite,
  input  logic [ADDR_WIDTH-1:0]   cacheAddr,
  input  logic [DATA_WIDTH-1:0]   cacheWriteData,
  output logic [DATA_WIDTH-1:0]   cacheReadData,
  output logic                    cacheDone,
  output logic                    cacheReady,
  output logic                    memRead,
  output logic                    memWrite,
  output logic [ADDR_WIDTH-1:0]   memAddr,
  output logic [DATA_WIDTH-1:0]   memWriteData,
  input  logic [DATA_WIDTH-1:0]   memReadData,
  input  logic                    memDone,
  output logic                    bufEmpty,
  output logic                    bufFull,
  output logic [$clog2(DEPTH):0]  bufCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {U_IDLE, U_ACK, U_MEMRD} u_state_t;
  typedef enum logic [1:0] {D_IDLE, D_WRITE, D_READ} d_state_t;

  u_state_t u_state, u_next;
  d_state_t d_state, d_next;

  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]      ent_vld;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_dat;

  logic                  coal_hit;
  logic [PTR_W-1:0]      coal_idx;
  logic                  rd_hit;
  logic [PTR_W-1:0]      rd_idx;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  push;
  logic                  pop;
  logic                  rd_miss_pend;
  logic                  mem_rd_done;

  // Coalesce target: the single valid copy of the address that is not on its way to RAM.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == cacheAddr) &&
          !((d_state == D_WRITE) && (PTR_W'(i) == head))) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  // Walk oldest to youngest so a re-written address returns its newest data.
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[head + PTR_W'(i)] && (ent_addr[head + PTR_W'(i)] == cacheAddr)) begin
        rd_hit = 1'b1;
        rd_idx = head + PTR_W'(i);
      end
    end
  end

  assign bufEmpty   = (count == '0);
  assign bufFull    = (count == CNT_MAX);
  assign bufCount   = count;
  assign cacheReady = rst && (u_state == U_IDLE) && (cacheRead || !bufFull || coal_hit);

  assign acc_rd       = cacheReady && cacheRead;
  assign acc_wr       = cacheReady && !cacheRead && cacheWrite;
  assign push         = acc_wr && !coal_hit;
  assign pop          = (d_state == D_WRITE) && memDone;
  assign rd_miss_pend = (u_state == U_MEMRD) && (d_state != D_READ);
  assign mem_rd_done  = (d_state == D_READ) && memDone;

  // Upstream FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) u_state <= U_IDLE;
    else      u_state <= u_next;
  end

  always_comb begin
    u_next = u_state;
    case (u_state)
      U_IDLE: begin
        if (acc_wr || (acc_rd && rd_hit)) u_next = U_ACK;
        else if (acc_rd)                  u_next = U_MEMRD;
      end
      U_ACK:   u_next = U_IDLE;
      U_MEMRD: if (mem_rd_done) u_next = U_ACK;
      default: u_next = U_IDLE;
    endcase
  end

  always_comb begin
    cacheDone     = (u_state == U_ACK);
    cacheReadData = rd_dat;
  end

  // Downstream FSM: a pending miss read overtakes queued drains, never an in-flight one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_state <= D_IDLE;
    else      d_state <= d_next;
  end

  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE: begin
        if (rd_miss_pend)   d_next = D_READ;
        else if (!bufEmpty) d_next = D_WRITE;
      end
      D_WRITE: if (memDone) d_next = D_IDLE;
      D_READ:  if (memDone) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  always_comb begin
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memAddr      = '0;
    memWriteData = '0;
    case (d_state)
      D_WRITE: begin
        memWrite     = 1'b1;
        memAddr      = ent_addr[head];
        memWriteData = ent_data[head];
      end
      D_READ: begin
        memRead = 1'b1;
        memAddr = rd_addr;
      end
      default: ;
    endcase
  end

  // Pointer and occupancy state; push is blocked when full so head==tail never collides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
      rd_addr <= '0;
      rd_dat  <= '0;
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_ONE;
      end
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PTR_ONE;
      end
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      if (acc_rd) begin
        rd_addr <= cacheAddr;
        if (rd_hit) rd_dat <= ent_data[rd_idx];
      end
      if (mem_rd_done) rd_dat <= memReadData;
    end
  end

  // Entry payload needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= cacheAddr;
      ent_data[tail] <= cacheWriteData;
    end else if (acc_wr) begin
      ent_data[coal_idx] <= cacheWriteData;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer with a latency-programmable, stallable RAM model.
module tb_write_buffer;

  logic        clk;
  logic        rst;
  logic        cacheRead, cacheWrite;
  logic [15:0] cacheAddr;
  logic [31:0] cacheWriteData;
  logic [31:0] cacheReadData;
  logic        cacheDone, cacheReady;
  logic        memRead, memWrite;
  logic [15:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memDone;
  logic        bufEmpty, bufFull;
  logic [2:0]  bufCount;

  write_buffer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cacheRead(cacheRead), .cacheWrite(cacheWrite),
    .cacheAddr(cacheAddr), .cacheWriteData(cacheWriteData),
    .cacheReadData(cacheReadData), .cacheDone(cacheDone), .cacheReady(cacheReady),
    .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
    .memWriteData(memWriteData), .memReadData(memReadData), .memDone(memDone),
    .bufEmpty(bufEmpty), .bufFull(bufFull), .bufCount(bufCount)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [256];
  logic [15:0] log_a [$];
  logic [31:0] log_d [$];
  logic [15:0] exp_a [$];
  logic [31:0] exp_d [$];
  int ram_lat   = 1;
  bit ram_stall = 0;
  int lat_cnt   = 0;
  int rd_cycles = 0;
  int both_hi   = 0;

  typedef struct packed {
    logic        is_rd;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [2:0]  exp_cnt;
    logic        exp_full;
  } vec_t;
  vec_t vt [11];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // RAM model: answers after ram_lat request cycles unless stalled; logs every write it performs.
  initial begin
    memDone = 0;
    memReadData = 0;
    for (int i = 0; i < 256; i++) ram[i] = 0;
    forever begin
      @(negedge clk);
      memDone = 0;
      if (memRead && memWrite) both_hi++;
      if (memRead) rd_cycles++;
      if (!rst) begin
        lat_cnt = 0;
      end else if ((memRead || memWrite) && !ram_stall) begin
        lat_cnt++;
        if (lat_cnt >= ram_lat) begin
          lat_cnt = 0;
          memDone = 1;
          if (memWrite) begin
            ram[memAddr[7:0]] = memWriteData;
            log_a.push_back(memAddr);
            log_d.push_back(memWriteData);
          end else begin
            memReadData = ram[memAddr[7:0]];
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " cacheDone"},     cacheDone, 0);
    check({tag, " cacheReady"},    cacheReady, 0);
    check({tag, " cacheReadData"}, cacheReadData, 0);
    check({tag, " memRead"},       memRead, 0);
    check({tag, " memWrite"},      memWrite, 0);
    check({tag, " memAddr"},       memAddr, 0);
    check({tag, " memWriteData"},  memWriteData, 0);
    check({tag, " bufEmpty"},      bufEmpty, 1);
    check({tag, " bufFull"},       bufFull, 0);
    check({tag, " bufCount"},      bufCount, 0);
  endtask

  task automatic cache_write(input logic [15:0] a, input logic [31:0] d, output int blocked);
    blocked = 0;
    @(negedge clk);
    cacheWrite = 1; cacheAddr = a; cacheWriteData = d;
    #1;
    while (!cacheReady && blocked < 300) begin
      blocked++;
      @(negedge clk); #1;
    end
    if (!cacheReady) begin
      check("write accept timeout", cacheReady, 1);
      cacheWrite = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    check("write done latency", cacheDone, 1);
    cacheWrite = 0;
  endtask

  task automatic cache_read(input logic [15:0] a, output logic [31:0] d, output int lat);
    int n = 0;
    lat = 0;
    d = 0;
    @(negedge clk);
    cacheRead = 1; cacheAddr = a;
    #1;
    while (!cacheReady && n < 300) begin
      n++;
      @(negedge clk); #1;
    end
    if (!cacheReady) begin
      check("read accept timeout", cacheReady, 1);
      cacheRead = 0;
      return;
    end
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
    end while (!cacheDone && lat < 300);
    check("read done seen", cacheDone, 1);
    d = cacheReadData;
    cacheRead = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(bufEmpty && !memWrite && !memRead) && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, " drained"}, bufEmpty && !memWrite && !memRead, 1);
  endtask

  task automatic check_log(input string name, input int base);
    check({name, " ram write count"}, log_a.size() - base, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      if (base + i < log_a.size()) begin
        check({name, " ram write addr"}, log_a[base + i], exp_a[i]);
        check({name, " ram write data"}, log_d[base + i], exp_d[i]);
      end
    end
  endtask

  initial begin
    int blk;
    int lat;
    int base;
    int rb;
    logic [31:0] got;

    rst = 0;
    cacheRead = 0; cacheWrite = 0; cacheAddr = 0; cacheWriteData = 0;

    // While RAM is stalled nothing pops, so every count below is exact.
    vt[0]  = '{1'b0, 16'h0050, 32'h11, 32'h0,  3'd1, 1'b0};
    vt[1]  = '{1'b0, 16'h0051, 32'h22, 32'h0,  3'd2, 1'b0};
    vt[2]  = '{1'b0, 16'h0051, 32'h33, 32'h0,  3'd2, 1'b0};
    vt[3]  = '{1'b1, 16'h0050, 32'h0,  32'h11, 3'd2, 1'b0};
    vt[4]  = '{1'b0, 16'h0050, 32'h44, 32'h0,  3'd3, 1'b0};
    vt[5]  = '{1'b1, 16'h0050, 32'h0,  32'h44, 3'd3, 1'b0};
    vt[6]  = '{1'b1, 16'h0051, 32'h0,  32'h33, 3'd3, 1'b0};
    vt[7]  = '{1'b0, 16'h0050, 32'h55, 32'h0,  3'd3, 1'b0};
    vt[8]  = '{1'b0, 16'h0052, 32'h66, 32'h0,  3'd4, 1'b1};
    vt[9]  = '{1'b1, 16'h0052, 32'h0,  32'h66, 3'd4, 1'b1};
    vt[10] = '{1'b0, 16'h0051, 32'h77, 32'h0,  3'd4, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1;
    #1;
    check("ready after reset release", cacheReady, 1);

    ram_lat = 1;
    ram_stall = 1;
    base = log_a.size();
    rb = rd_cycles;
    for (int i = 0; i < 11; i++) begin
      if (vt[i].is_rd) begin
        cache_read(vt[i].a, got, lat);
        check("table read data", got, vt[i].exp_rd);
        check("table read latency", lat, 1);
      end else begin
        cache_write(vt[i].a, vt[i].d, blk);
      end
      check("table bufCount", bufCount, vt[i].exp_cnt);
      check("table bufFull", bufFull, vt[i].exp_full);
    end
    check("table no memRead", rd_cycles - rb, 0);
    ram_stall = 0;
    wait_drain("table");
    exp_a = '{16'h0050, 16'h0051, 16'h0050, 16'h0052};
    exp_d = '{32'h11, 32'h77, 32'h55, 32'h66};
    check_log("table", base);

    // Single write, RAM latency 3
    ram_lat = 3;
    base = log_a.size();
    cache_write(16'h0010, 32'hCAFE_BABE, blk);
    check("single write not blocked", blk, 0);
    wait_drain("single");
    check("single ram value", ram[8'h10], 32'hCAFE_BABE);
    check("single bufEmpty", bufEmpty, 1);

    // Read-after-write served from buffer while drain is stuck
    ram_stall = 1;
    rb = rd_cycles;
    cache_write(16'h0020, 32'hAAAA_5555, blk);
    cache_read(16'h0020, got, lat);
    check("raw read data", got, 32'hAAAA_5555);
    check("raw read latency", lat, 1);
    check("raw no memRead", rd_cycles - rb, 0);
    ram_stall = 0;
    wait_drain("raw");
    check("raw ram value", ram[8'h20], 32'hAAAA_5555);

    // Coalescing: 0x002F occupies the in-flight slot so both 0x0030 writes land in one entry
    ram_stall = 1;
    base = log_a.size();
    cache_write(16'h002F, 32'hF0F0, blk);
    cache_write(16'h0030, 32'h1, blk);
    check("coalesce count after first", bufCount, 2);
    cache_write(16'h0030, 32'h2, blk);
    check("coalesce count after second", bufCount, 2);
    ram_stall = 0;
    wait_drain("coalesce");
    exp_a = '{16'h002F, 16'h0030};
    exp_d = '{32'hF0F0, 32'h2};
    check_log("coalesce", base);

    // Full buffer: fifth write waits for the first memDone
    ram_lat = 1;
    ram_stall = 1;
    base = log_a.size();
    for (int k = 0; k < 4; k++) cache_write(16'h0040 + 16'(k), 32'h400 + 32'(k), blk);
    check("full flag", bufFull, 1);
    check("full ready low", cacheReady, 0);
    fork
      cache_write(16'h0044, 32'h444, blk);
      begin
        repeat (6) @(negedge clk);
        ram_stall = 0;
      end
    join
    check("full write blocked until drain", blk >= 6, 1);
    wait_drain("full");
    exp_a = '{16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0044};
    exp_d = '{32'h400, 32'h401, 32'h402, 32'h403, 32'h444};
    check_log("full", base);

    // Read miss overtakes the queued entry but not the in-flight one
    ram[8'hFF] = 32'h1234_5678;
    ram_lat = 2;
    ram_stall = 1;
    base = log_a.size();
    rb = rd_cycles;
    cache_write(16'h0060, 32'h600, blk);
    cache_write(16'h0061, 32'h610, blk);
    check("miss setup count", bufCount, 2);
    fork
      cache_read(16'h00FF, got, lat);
      begin
        repeat (3) @(negedge clk);
        ram_stall = 0;
      end
    join
    check("miss read data", got, 32'h1234_5678);
    check("miss writes before read", log_a.size() - base, 1);
    check("miss count at done", bufCount, 1);
    check("miss memRead used", rd_cycles > rb, 1);
    wait_drain("miss");
    exp_a = '{16'h0060, 16'h0061};
    exp_d = '{32'h600, 32'h610};
    check_log("miss", base);

    // Reset in the middle of a drain
    ram_lat = 1;
    ram_stall = 1;
    cache_write(16'h0070, 32'h700, blk);
    cache_write(16'h0071, 32'h710, blk);
    cache_write(16'h0072, 32'h720, blk);
    check("midreset memWrite before", memWrite, 1);
    check("midreset count before", bufCount, 3);
    base = log_a.size();
    @(negedge clk);
    rst = 0;
    #1;
    check_reset("midreset");
    ram_stall = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (10) @(negedge clk);
    #1;
    check("midreset no ram writes", log_a.size() - base, 0);
    check("midreset ram untouched", ram[8'h70], 0);
    check("midreset bufEmpty", bufEmpty, 1);
    check("midreset ready", cacheReady, 1);
    cache_write(16'h0080, 32'h8080, blk);
    wait_drain("postreset");
    check("postreset ram value", ram[8'h80], 32'h8080);

    check("memRead and memWrite never together", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
